// File: rtl/bp_btb_upd_arb.sv
// BTB write-port arbiter: execute updates win, predecoder updates queue in a merging FIFO.
// Optional drop statistics enabled by defining RIVER_BP_ARB_STAT_EN.
module bp_btb_upd_arb #(
    parameter int ADDR_BITS = 64,
    parameter int DEPTH     = 4,
    parameter int PTR_BITS  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_e_valid,
    input  logic [ADDR_BITS-1:0] i_e_pc,
    input  logic [ADDR_BITS-1:0] i_e_npc,
    input  logic                 i_pd_valid,
    input  logic [ADDR_BITS-1:0] i_pd_pc,
    input  logic [ADDR_BITS-1:0] i_pd_npc,
    output logic                 o_pd_ready,
    input  logic                 i_flush,
    output logic                 o_we,
    output logic [ADDR_BITS-1:0] o_we_pc,
    output logic [ADDR_BITS-1:0] o_we_npc,
    output logic                 o_we_exec,
    output logic [31:0]          o_stat_drop
);

    localparam logic [PTR_BITS:0] CNT_FULL = (PTR_BITS+1)'(DEPTH);

    logic [ADDR_BITS-1:0] q_pc  [DEPTH];
    logic [ADDR_BITS-1:0] q_npc [DEPTH];
    logic [DEPTH-1:0]     q_vld;
    logic [PTR_BITS-1:0]  rd_ptr;
    logic [PTR_BITS-1:0]  wr_ptr;
    logic [PTR_BITS:0]    cnt;

    logic [DEPTH-1:0]     e_hit;
    logic [DEPTH-1:0]     pd_hit;
    logic [DEPTH-1:0]     vld_nxt;
    logic [PTR_BITS:0]    cnt_nxt;
    logic                 push;
    logic                 coll;
    logic                 push_ok;
    logic                 push_new;
    logic                 push_merge;
    logic                 pop;
    logic                 pop_wr;

    logic                 we_p1;
    logic [ADDR_BITS-1:0] we_pc_p1;
    logic [ADDR_BITS-1:0] we_npc_p1;
    logic                 we_exec_p1;

    assign o_pd_ready = (cnt != CNT_FULL);

    always_comb begin
        e_hit      = '0;
        pd_hit     = '0;
        push       = i_pd_valid & o_pd_ready;
        coll       = push & i_e_valid & (i_pd_pc == i_e_pc);
        // An invalidated head is retired even while execute owns the port.
        pop        = (cnt != '0) & (~q_vld[rd_ptr] | ~i_e_valid);
        pop_wr     = pop & q_vld[rd_ptr] & ~i_e_valid & ~i_flush;
        for (int i = 0; i < DEPTH; i++) begin
            e_hit[i]  = q_vld[i] & i_e_valid & (q_pc[i] == i_e_pc);
            // The head leaving this cycle cannot absorb a merge; the update queues anew.
            pd_hit[i] = q_vld[i] & (q_pc[i] == i_pd_pc) & ~(pop && (PTR_BITS'(i) == rd_ptr));
        end
        push_ok    = push & ~i_flush & ~coll;
        push_merge = push_ok & (|pd_hit);
        push_new   = push_ok & ~(|pd_hit);
        vld_nxt    = q_vld & ~e_hit;
        if (pop) begin
            vld_nxt[rd_ptr] = 1'b0;
        end
        if (push_new) begin
            vld_nxt[wr_ptr] = 1'b1;
        end
        cnt_nxt    = cnt + (PTR_BITS+1)'(push_new) - (PTR_BITS+1)'(pop);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            q_vld  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (i_flush) begin
            q_vld  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            q_vld  <= vld_nxt;
            cnt    <= cnt_nxt;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_new) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // Entry payload is qualified by q_vld, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (push_new) begin
            q_pc[wr_ptr]  <= i_pd_pc;
            q_npc[wr_ptr] <= i_pd_npc;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (push_merge && pd_hit[i]) begin
                q_npc[i] <= i_pd_npc;
            end
        end
    end

    // Stage p1: registered BTB write request
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            we_p1      <= 1'b0;
            we_pc_p1   <= '0;
            we_npc_p1  <= '0;
            we_exec_p1 <= 1'b0;
        end else begin
            we_p1      <= i_e_valid | pop_wr;
            we_exec_p1 <= i_e_valid;
            if (i_e_valid) begin
                we_pc_p1  <= i_e_pc;
                we_npc_p1 <= i_e_npc;
            end else if (pop_wr) begin
                we_pc_p1  <= q_pc[rd_ptr];
                we_npc_p1 <= q_npc[rd_ptr];
            end
        end
    end

    assign o_we      = we_p1;
    assign o_we_pc   = we_pc_p1;
    assign o_we_npc  = we_npc_p1;
    assign o_we_exec = we_exec_p1;

`ifdef RIVER_BP_ARB_STAT_EN
    function automatic logic [31:0] popcnt(input logic [DEPTH-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    logic [31:0] drop_n;
    logic [31:0] stat_q;

    // A flush supersedes exec invalidation so no entry is counted twice.
    always_comb begin
        drop_n = '0;
        if (push && (i_flush || coll)) begin
            drop_n = 32'd1;
        end
        if (i_flush) begin
            drop_n = drop_n + popcnt(q_vld);
        end else begin
            drop_n = drop_n + popcnt(e_hit);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= sat_add(stat_q, drop_n);
        end
    end

    assign o_stat_drop = stat_q;
`else
    assign o_stat_drop = '0;
`endif

endmodule

// File: tb/tb_bp_btb_upd_arb.sv
// Directed self-checking bench for bp_btb_upd_arb; stat expectations follow RIVER_BP_ARB_STAT_EN.
module tb_bp_btb_upd_arb;

`ifdef RIVER_BP_ARB_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_e_valid;
    logic [63:0] i_e_pc;
    logic [63:0] i_e_npc;
    logic        i_pd_valid;
    logic [63:0] i_pd_pc;
    logic [63:0] i_pd_npc;
    logic        o_pd_ready;
    logic        i_flush;
    logic        o_we;
    logic [63:0] o_we_pc;
    logic [63:0] o_we_npc;
    logic        o_we_exec;
    logic [31:0] o_stat_drop;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 i_clk = ~i_clk;

    bp_btb_upd_arb #(.ADDR_BITS(64), .DEPTH(4), .PTR_BITS(2)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_e_valid   (i_e_valid),
        .i_e_pc      (i_e_pc),
        .i_e_npc     (i_e_npc),
        .i_pd_valid  (i_pd_valid),
        .i_pd_pc     (i_pd_pc),
        .i_pd_npc    (i_pd_npc),
        .o_pd_ready  (o_pd_ready),
        .i_flush     (i_flush),
        .o_we        (o_we),
        .o_we_pc     (o_we_pc),
        .o_we_npc    (o_we_npc),
        .o_we_exec   (o_we_exec),
        .o_stat_drop (o_stat_drop)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic idle();
        i_e_valid  = 1'b0;
        i_e_pc     = '0;
        i_e_npc    = '0;
        i_pd_valid = 1'b0;
        i_pd_pc    = '0;
        i_pd_npc   = '0;
        i_flush    = 1'b0;
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        i_rst = 1'b1;
        cyc();
        cyc();
        i_rst = 1'b0;
    endtask

    task automatic exec_req(input logic [63:0] pc, input logic [63:0] npc);
        i_e_valid = 1'b1;
        i_e_pc    = pc;
        i_e_npc   = npc;
    endtask

    task automatic pd_req(input logic [63:0] pc, input logic [63:0] npc);
        i_pd_valid = 1'b1;
        i_pd_pc    = pc;
        i_pd_npc   = npc;
    endtask

    task automatic chk_wr(input string tag, input logic ex, input logic [63:0] pc, input logic [63:0] npc);
        chk({tag, "_we"}, 64'(o_we), 64'd1);
        chk({tag, "_exec"}, 64'(o_we_exec), 64'(ex));
        chk({tag, "_pc"}, o_we_pc, pc);
        chk({tag, "_npc"}, o_we_npc, npc);
    endtask

    initial begin
        idle();
        i_rst = 1'b0;
        #2 i_rst = 1'b1;
        cyc();
        chk("rst_we", 64'(o_we), 64'd0);
        chk("rst_pc", o_we_pc, 64'd0);
        chk("rst_npc", o_we_npc, 64'd0);
        chk("rst_exec", 64'(o_we_exec), 64'd0);
        chk("rst_stat", 64'(o_stat_drop), 64'd0);
        i_rst = 1'b0;
        #1;
        chk("rst_ready", 64'(o_pd_ready), 64'd1);

        // Three predecoder pushes drain in order, one cycle after each push.
        pd_req(64'h100, 64'h1100);
        cyc();
        chk("t1_we0", 64'(o_we), 64'd0);
        pd_req(64'h200, 64'h1200);
        cyc();
        chk_wr("t1_a", 1'b0, 64'h100, 64'h1100);
        pd_req(64'h300, 64'h1300);
        cyc();
        chk_wr("t1_b", 1'b0, 64'h200, 64'h1200);
        idle();
        cyc();
        chk_wr("t1_c", 1'b0, 64'h300, 64'h1300);
        cyc();
        chk("t1_end", 64'(o_we), 64'd0);

        // Execute owns the port for 6 cycles while the FIFO fills.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            exec_req(64'h1000 + 64'(16 * i), 64'h9000 + 64'(i));
            if (i < 4) pd_req(64'hA00 + 64'(16 * i), 64'hE00 + 64'(i));
            else i_pd_valid = 1'b0;
            cyc();
            chk_wr("t2_ex", 1'b1, 64'h1000 + 64'(16 * i), 64'h9000 + 64'(i));
            if (i == 2) chk("t2_rdy3", 64'(o_pd_ready), 64'd1);
            if (i >= 3) chk("t2_full", 64'(o_pd_ready), 64'd0);
        end
        idle();
        for (int j = 0; j < 4; j++) begin
            cyc();
            chk_wr("t2_pd", 1'b0, 64'hA00 + 64'(16 * j), 64'hE00 + 64'(j));
            if (j == 0) chk("t2_rdy_back", 64'(o_pd_ready), 64'd1);
        end
        cyc();
        chk("t2_end", 64'(o_we), 64'd0);

        // Second push to the same pc merges into the queued entry.
        do_reset();
        exec_req(64'h2000, 64'h2001);
        pd_req(64'h40, 64'h80);
        cyc();
        chk_wr("t3_ex0", 1'b1, 64'h2000, 64'h2001);
        exec_req(64'h2010, 64'h2011);
        pd_req(64'h40, 64'hC0);
        cyc();
        chk_wr("t3_ex1", 1'b1, 64'h2010, 64'h2011);
        idle();
        cyc();
        chk_wr("t3_pd", 1'b0, 64'h40, 64'hC0);
        cyc();
        chk("t3_single", 64'(o_we), 64'd0);
        chk("t3_stat", 64'(o_stat_drop), 64'd0);

        // Execute to a queued pc invalidates that entry.
        do_reset();
        pd_req(64'h500, 64'h5500);
        cyc();
        chk("t4_we0", 64'(o_we), 64'd0);
        idle();
        exec_req(64'h500, 64'h600);
        cyc();
        chk_wr("t4_ex", 1'b1, 64'h500, 64'h600);
        idle();
        cyc();
        chk("t4_nowr", 64'(o_we), 64'd0);
        chk("t4_stat", 64'(o_stat_drop), STAT ? 64'd1 : 64'd0);
        cyc();
        chk("t4_nowr2", 64'(o_we), 64'd0);

        // Same-cycle pc collision: execute wins, predecoder update dropped.
        do_reset();
        exec_req(64'h900, 64'h901);
        pd_req(64'h900, 64'h902);
        cyc();
        chk_wr("t4b_ex", 1'b1, 64'h900, 64'h901);
        idle();
        cyc();
        chk("t4b_nowr", 64'(o_we), 64'd0);
        chk("t4b_stat", 64'(o_stat_drop), STAT ? 64'd1 : 64'd0);

        // Flush with 3 queued, a push and an exec in the same cycle.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exec_req(64'h3000 + 64'(16 * i), 64'h3100 + 64'(i));
            pd_req(64'hB00 + 64'(16 * i), 64'hF00 + 64'(i));
            cyc();
        end
        i_flush = 1'b1;
        pd_req(64'hB30, 64'hF03);
        exec_req(64'h700, 64'h777);
        cyc();
        chk_wr("t5_ex", 1'b1, 64'h700, 64'h777);
        chk("t5_ready", 64'(o_pd_ready), 64'd1);
        idle();
        cyc();
        chk("t5_empty", 64'(o_we), 64'd0);
        chk("t5_stat", 64'(o_stat_drop), STAT ? 64'd4 : 64'd0);
        cyc();
        chk("t5_empty2", 64'(o_we), 64'd0);

        // Flush suppresses a head pop selected in the same cycle.
        do_reset();
        pd_req(64'hC00, 64'hC80);
        cyc();
        idle();
        i_flush = 1'b1;
        cyc();
        chk("t5b_supp", 64'(o_we), 64'd0);
        idle();
        cyc();
        chk("t5b_nowr", 64'(o_we), 64'd0);
        chk("t5b_stat", 64'(o_stat_drop), STAT ? 64'd1 : 64'd0);

        // Asynchronous reset in the middle of a drain.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exec_req(64'h4000 + 64'(16 * i), 64'h4100 + 64'(i));
            pd_req(64'hD00 + 64'(16 * i), 64'hD80 + 64'(i));
            cyc();
        end
        idle();
        cyc();
        chk_wr("t6_pd", 1'b0, 64'hD00, 64'hD80);
        #2 i_rst = 1'b1;
        #1;
        chk("t6_async_we", 64'(o_we), 64'd0);
        chk("t6_async_pc", o_we_pc, 64'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t6_nostale", 64'(o_we), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
